// File: rtl/xoodyak_block_packer_if.sv
// Word-stream input and block output bundle for the Xoodyak block packer.
// master = feeder/core side, slave = packer.
interface xoodyak_block_packer_if #(
    parameter int BLK_W = 352
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_word;
    logic [2:0]       in_bytes;
    logic             in_last;
    logic [4:0]       in_cmd;

    logic             blk_valid;
    logic             blk_ready;
    logic [BLK_W-1:0] blk_data;
    logic [4:0]       blk_opmode;
    logic [5:0]       blk_nbytes;
    logic             blk_first;
    logic             blk_last;
    logic             err;

    modport master (
        output in_valid, in_word, in_bytes, in_last, in_cmd, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_opmode, blk_nbytes,
               blk_first, blk_last, err
    );

    modport slave (
        input  in_valid, in_word, in_bytes, in_last, in_cmd, blk_ready,
        output in_ready, blk_valid, blk_data, blk_opmode, blk_nbytes,
               blk_first, blk_last, err
    );
endinterface

// File: rtl/xoodyak_block_packer.sv
// Packs a byte-counted 32-bit word stream MSB-first into rate-sized blocks
// for the Xoodyak core. One message per command; capacity follows the
// latched opmode.
//
// state  | meaning
// IDLE   | waiting for the first word of a message
// FILL   | message in progress, collecting words into the block
// EMIT   | block presented on blk_*, input stalled until accepted
module xoodyak_block_packer #(
    parameter int BLK_W       = 352,
    parameter int KEY_BYTES   = 16,
    parameter int ABS_K_BYTES = 44,
    parameter int ABS_H_BYTES = 16,
    parameter int CRYPT_BYTES = 24
) (
    input logic                  eph1,
    input logic                  reset,
    xoodyak_block_packer_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_EMIT} state_t;

    state_t           state_q, state_d;
    logic [5:0]       ptr_q, ptr_d;
    logic [BLK_W-1:0] data_q, data_d;
    logic [4:0]       cmd_q, cmd_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             err_q, err_d;

    logic [4:0]       wr_cmd;
    logic [5:0]       cap;
    logic [6:0]       sum;
    logic [5:0]       ptr_nx;
    logic [31:0]      mask;
    logic [BLK_W-1:0] wr_ext;
    logic             bad;
    logic             in_fire;

    function automatic logic [5:0] cap_of(input logic [4:0] c);
        case (c[3:0])
            4'd0, 4'd1: return 6'(KEY_BYTES);
            4'd2, 4'd3: return c[4] ? 6'(ABS_H_BYTES) : 6'(ABS_K_BYTES);
            4'd4, 4'd5: return 6'(CRYPT_BYTES);
            default:    return 6'd0;
        endcase
    endfunction

    assign bus.in_ready   = reset & (state_q != S_EMIT);
    assign bus.blk_valid  = (state_q == S_EMIT);
    assign bus.blk_data   = data_q;
    assign bus.blk_opmode = cmd_q;
    assign bus.blk_nbytes = ptr_q;
    assign bus.blk_first  = first_q;
    assign bus.blk_last   = last_q;
    assign bus.err        = err_q;

    assign in_fire = bus.in_valid & bus.in_ready;

    // Byte placement, error detection and next-state selection.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        cmd_d   = cmd_q;
        first_d = first_q;
        last_d  = last_q;
        err_d   = err_q;

        // The first word of a message is judged against its own cmd,
        // which is not latched until the transfer edge.
        wr_cmd = (state_q == S_IDLE) ? bus.in_cmd : cmd_q;
        cap    = cap_of(wr_cmd);
        sum    = {1'b0, ptr_q} + {4'b0000, bus.in_bytes};
        bad    = (bus.in_bytes > 3'd4) ||
                 ((bus.in_bytes < 3'd4) && !bus.in_last) ||
                 ((cap == 6'd0) && (bus.in_bytes != 3'd0)) ||
                 (sum > {1'b0, cap});
        // Keep only the left-justified valid bytes so unused block bytes stay 0.
        mask   = ~(32'hffff_ffff >> {bus.in_bytes, 3'b000});
        wr_ext = {bus.in_word & mask, {(BLK_W-32){1'b0}}} >> {ptr_q, 3'b000};
        ptr_nx = bad ? ptr_q : sum[5:0];

        case (state_q)
            S_IDLE, S_FILL: begin
                if (in_fire) begin
                    if (state_q == S_IDLE) begin
                        cmd_d   = bus.in_cmd;
                        first_d = 1'b1;
                    end
                    if (bad) begin
                        err_d = 1'b1;
                    end else begin
                        data_d = data_q | wr_ext;
                        ptr_d  = sum[5:0];
                    end
                    last_d  = bus.in_last;
                    state_d = (bus.in_last || (ptr_nx == cap)) ? S_EMIT : S_FILL;
                end
            end
            S_EMIT: begin
                if (bus.blk_ready) begin
                    data_d  = '0;
                    ptr_d   = 6'd0;
                    first_d = 1'b0;
                    state_d = last_q ? S_IDLE : S_FILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial or pending block.
    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 6'd0;
            data_q  <= '0;
            cmd_q   <= 5'd0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            cmd_q   <= cmd_d;
            first_q <= first_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

endmodule
